// File: rtl/csr_ctrl_if.sv
// csr_ctrl_if: writeback-stage instruction bundle between the pipeline and csr_ctrl.
//   master (pipeline): drives ws_valid, ws_pc, ws_csr_num, ws_rd_value, ws_rj_value, ws_dest,
//                      ws_op_*, ws_exc, ws_ecode, ws_esubcode; receives ws_ready
//   slave (csr_ctrl):  the reverse
interface csr_ctrl_if;
    logic        ws_valid;
    logic        ws_ready;
    logic [31:0] ws_pc;
    logic [13:0] ws_csr_num;
    logic [31:0] ws_rd_value;
    logic [31:0] ws_rj_value;
    logic [4:0]  ws_dest;
    logic        ws_op_csrrd;
    logic        ws_op_csrwr;
    logic        ws_op_csrxchg;
    logic        ws_op_ertn;
    logic        ws_op_syscall;
    logic        ws_exc;
    logic [5:0]  ws_ecode;
    logic [8:0]  ws_esubcode;
    modport master (
        output ws_valid, ws_pc, ws_csr_num, ws_rd_value, ws_rj_value, ws_dest,
               ws_op_csrrd, ws_op_csrwr, ws_op_csrxchg, ws_op_ertn, ws_op_syscall,
               ws_exc, ws_ecode, ws_esubcode,
        input  ws_ready
    );
    modport slave (
        input  ws_valid, ws_pc, ws_csr_num, ws_rd_value, ws_rj_value, ws_dest,
               ws_op_csrrd, ws_op_csrwr, ws_op_csrxchg, ws_op_ertn, ws_op_syscall,
               ws_exc, ws_ecode, ws_esubcode,
        output ws_ready
    );
endinterface

// File: rtl/csr_ctrl.sv
// csr_ctrl: writeback-stage CSR initiator; turns csrrd/csrwr/csrxchg, exceptions and ertn
// into CSR-file strobes, returns old CSR values to the GPR file, redirects fetch and flushes.
//   clk, reset            clock, synchronous active-high reset
//   ws (slave)            writeback instruction bundle with ws_valid/ws_ready handshake
//   csr_*  out            read/write address, data, write enables, exception/return strobes
//   csr_rdata/era/eentry  values from the CSR file (rdata combinational)
//   rf_*                  registered GPR write-back of the old CSR value
//   flush, redirect_*     pipeline kill and fetch redirect
//   Optional macro CSR_CTRL_INT_EN adds int_pending/csr_crmd_ie interrupt inputs.
module csr_ctrl #(
    parameter int          FLUSH_CYCLES = 2,
    parameter logic [5:0]  ECODE_SYS    = 6'h0B
) (
    input  logic        clk,
    input  logic        reset,
`ifdef CSR_CTRL_INT_EN
    input  logic        int_pending,
    input  logic        csr_crmd_ie,
`endif
    csr_ctrl_if.slave   ws,
    output logic [13:0] csr_raddr,
    output logic [31:0] csr_rj_value,
    output logic [1:0]  csr_we,
    output logic [13:0] csr_waddr,
    output logic [31:0] csr_wdata,
    output logic [31:0] csr_pc,
    output logic        csr_is_exc,
    output logic        csr_is_ret,
    output logic [5:0]  csr_ecode,
    output logic [8:0]  csr_esubcode,
    input  logic [31:0] csr_rdata,
    input  logic [31:0] csr_era,
    input  logic [31:0] csr_eentry,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic        flush,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc
);
    localparam int CW = FLUSH_CYCLES > 0 ? $clog2(FLUSH_CYCLES + 1) : 1;
    typedef enum logic [1:0] {IDLE, EXC, DRAIN} state_t;
    state_t        state;
    logic [CW-1:0] cnt;
    logic          acc, take_int, is_exc, is_ret, is_csr, in_exc, in_drain;
    state_t        after_redirect;
`ifdef CSR_CTRL_INT_EN
    assign take_int = int_pending && csr_crmd_ie;
`else
    assign take_int = 1'b0;
`endif
    assign ws.ws_ready = state == IDLE;
    // every strobe is gated by reset so nothing leaks out while the state is being cleared
    assign acc      = !reset && ws.ws_valid && ws.ws_ready;
    assign is_exc   = acc && (ws.ws_exc || ws.ws_op_syscall || take_int);
    assign is_ret   = acc && !is_exc && ws.ws_op_ertn;
    assign is_csr   = acc && !is_exc && !is_ret && (ws.ws_op_csrrd || ws.ws_op_csrwr || ws.ws_op_csrxchg);
    assign in_exc   = !reset && state == EXC;
    assign in_drain = !reset && state == DRAIN;
    assign after_redirect = FLUSH_CYCLES == 0 ? IDLE : DRAIN;
    assign csr_raddr    = ws.ws_csr_num;
    assign csr_waddr    = ws.ws_csr_num;
    assign csr_wdata    = ws.ws_rd_value;
    assign csr_rj_value = ws.ws_rj_value;
    assign csr_pc       = ws.ws_pc;
    assign csr_we       = !is_csr ? 2'b00 : ws.ws_op_csrwr ? 2'b01 : ws.ws_op_csrxchg ? 2'b10 : 2'b00;
    assign csr_is_exc   = is_exc;
    assign csr_is_ret   = is_ret;
    // interrupts outrank upstream exceptions, which outrank syscall
    assign csr_ecode    = !is_exc ? 6'd0 : take_int ? 6'd0 : ws.ws_exc ? ws.ws_ecode : ECODE_SYS;
    assign csr_esubcode = !is_exc || take_int || !ws.ws_exc ? 9'd0 : ws.ws_esubcode;
    assign redirect_valid = in_exc || is_ret;
    assign redirect_pc    = in_exc ? csr_eentry : csr_era;
    assign flush          = in_exc || in_drain || is_ret;
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else begin
            rf_we <= is_csr && ws.ws_dest != 5'd0;
            if (is_csr) begin
                rf_waddr <= ws.ws_dest;
                rf_wdata <= csr_rdata;
            end
            case (state)
                IDLE: begin
                    if (is_exc) state <= EXC;
                    else if (is_ret) begin
                        cnt   <= CW'(FLUSH_CYCLES);
                        state <= after_redirect;
                    end
                end
                EXC: begin
                    cnt   <= CW'(FLUSH_CYCLES);
                    state <= after_redirect;
                end
                DRAIN: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == CW'(1)) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_csr_ctrl.sv
// tb_csr_ctrl: scoreboard bench for csr_ctrl; the driver pushes per-cycle expected outputs,
// a negedge monitor pops and compares. The bench also models a small CSR file.
module tb_csr_ctrl;
    typedef struct packed {
        logic        ready;
        logic [1:0]  we;
        logic        exc;
        logic        ret;
        logic [5:0]  ecode;
        logic [8:0]  esub;
        logic        flush;
        logic        rv;
        logic [31:0] rpc;
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic [31:0] rf_wdata;
        logic [31:0] rj;
        logic [13:0] raddr;
        logic [31:0] wdata;
    } obs_t;
    localparam logic [4:0] NOP = 5'b00000, RD = 5'b10000, WR = 5'b01000, XCHG = 5'b00100,
                           ERTN = 5'b00010, SYS = 5'b00001;
    logic        clk = 0, reset = 1;
    logic [31:0] csr_era = 0, csr_eentry = 0;
    logic [13:0] csr_raddr, csr_waddr;
    logic [31:0] csr_rj_value, csr_wdata, csr_pc, csr_rdata, rf_wdata, redirect_pc;
    logic [1:0]  csr_we;
    logic        csr_is_exc, csr_is_ret, rf_we, flush, redirect_valid;
    logic [5:0]  csr_ecode;
    logic [8:0]  csr_esubcode;
    logic [4:0]  rf_waddr;
`ifdef CSR_CTRL_INT_EN
    logic        int_pending = 0, csr_crmd_ie = 0;
`endif
    logic [31:0] csr_mem [0:63] = '{default: 32'd0};
    obs_t        q [$];
    string       nq [$];
    int          compared = 0, mismatched = 0;
    csr_ctrl_if ws_if ();
    csr_ctrl dut (
        .clk(clk), .reset(reset),
`ifdef CSR_CTRL_INT_EN
        .int_pending(int_pending), .csr_crmd_ie(csr_crmd_ie),
`endif
        .ws(ws_if),
        .csr_raddr(csr_raddr), .csr_rj_value(csr_rj_value), .csr_we(csr_we),
        .csr_waddr(csr_waddr), .csr_wdata(csr_wdata), .csr_pc(csr_pc),
        .csr_is_exc(csr_is_exc), .csr_is_ret(csr_is_ret), .csr_ecode(csr_ecode),
        .csr_esubcode(csr_esubcode), .csr_rdata(csr_rdata), .csr_era(csr_era),
        .csr_eentry(csr_eentry), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .flush(flush), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );
    always #5 clk = ~clk;
    // CSR file model: combinational read, full or masked write at the clock edge
    assign csr_rdata = csr_mem[csr_raddr[5:0]];
    always @(posedge clk) begin
        if (csr_we == 2'b01) csr_mem[csr_waddr[5:0]] <= csr_wdata;
        else if (csr_we == 2'b10)
            csr_mem[csr_waddr[5:0]] <= (csr_mem[csr_waddr[5:0]] & ~csr_rj_value) | (csr_wdata & csr_rj_value);
    end
    always @(negedge clk) begin
        if (q.size() > 0) begin
            obs_t e, a;
            string n;
            e = q.pop_front();
            n = nq.pop_front();
            a = '{ready: ws_if.ws_ready, we: csr_we, exc: csr_is_exc, ret: csr_is_ret,
                  ecode: csr_ecode, esub: csr_esubcode, flush: flush, rv: redirect_valid,
                  rpc: redirect_pc, rf_we: rf_we, rf_waddr: rf_waddr, rf_wdata: rf_wdata,
                  rj: csr_rj_value, raddr: csr_raddr, wdata: csr_wdata};
            if (!e.rv) begin
                a.rpc = '0;
                e.rpc = '0;
            end
            compared++;
            if (a !== e) begin
                mismatched++;
                $display("FAIL %s: got %h expected %h", n, a, e);
            end
        end
    end
    task automatic drive(input logic v, input logic [4:0] op, input logic [13:0] num,
                         input logic [31:0] rd, input logic [31:0] rj, input logic [4:0] dest,
                         input logic exc, input logic [5:0] ec, input logic [8:0] es);
        ws_if.ws_valid = v;
        {ws_if.ws_op_csrrd, ws_if.ws_op_csrwr, ws_if.ws_op_csrxchg, ws_if.ws_op_ertn, ws_if.ws_op_syscall} = op;
        ws_if.ws_csr_num  = num;
        ws_if.ws_rd_value = rd;
        ws_if.ws_rj_value = rj;
        ws_if.ws_dest     = dest;
        ws_if.ws_exc      = exc;
        ws_if.ws_ecode    = ec;
        ws_if.ws_esubcode = es;
        ws_if.ws_pc       = 32'h1C00_0100;
    endtask
    task automatic idle();
        drive(0, NOP, 14'h0, 0, 0, 0, 0, 0, 0);
    endtask
    task automatic step(input string n, input logic rdy, input logic [1:0] we, input logic exc,
                        input logic ret, input logic [5:0] ec, input logic [8:0] es, input logic fl,
                        input logic rv, input logic [31:0] rpc, input logic rfwe,
                        input logic [4:0] rfwa, input logic [31:0] rfwd);
        q.push_back('{ready: rdy, we: we, exc: exc, ret: ret, ecode: ec, esub: es, flush: fl,
                      rv: rv, rpc: rpc, rf_we: rfwe, rf_waddr: rfwa, rf_wdata: rfwd,
                      rj: ws_if.ws_rj_value, raddr: ws_if.ws_csr_num, wdata: ws_if.ws_rd_value});
        nq.push_back(n);
        @(posedge clk);
        #1;
    endtask
    initial begin
        csr_eentry = 32'h1C00_8000;
        csr_era    = 32'h1C00_0104;
        drive(1, WR, 14'h30, 32'hAAAA, 0, 4, 0, 0, 0);
        @(posedge clk);
        #1;
        step("reset_state", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'd0, 0);
        reset = 0;
        drive(1, WR, 14'h30, 32'h1234_5678, 0, 4, 0, 0, 0);
        step("csrwr_accept", 1, 2'b01, 0, 0, 0, 0, 0, 0, 0, 0, 5'd0, 0);
        drive(1, WR, 14'h31, 32'hCAFE_F00D, 0, 5, 0, 0, 0);
        step("csrwr_rf_old_save0", 1, 2'b01, 0, 0, 0, 0, 0, 0, 0, 1, 5'd4, 32'h0);
        drive(1, XCHG, 14'h31, 32'hFFFF_FFFF, 32'h0000_00FF, 0, 0, 0, 0);
        step("csrxchg_accept", 1, 2'b10, 0, 0, 0, 0, 0, 0, 0, 1, 5'd5, 32'h0);
        drive(1, RD, 14'h31, 0, 0, 6, 0, 0, 0);
        step("csrrd_after_xchg_r0", 1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 5'd0, 32'hCAFE_F00D);
        idle();
        step("csrrd_rf_masked", 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5'd6, 32'hCAFE_F0FF);
        drive(1, SYS, 14'h0, 0, 0, 3, 0, 0, 0);
        step("syscall_exc", 1, 0, 1, 0, 6'h0B, 0, 0, 0, 0, 0, 5'd6, 32'hCAFE_F0FF);
        drive(1, WR, 14'h30, 32'hDEAD, 0, 7, 0, 0, 0);
        step("syscall_redirect", 0, 0, 0, 0, 0, 0, 1, 1, 32'h1C00_8000, 0, 5'd6, 32'hCAFE_F0FF);
        step("syscall_drain1", 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 5'd6, 32'hCAFE_F0FF);
        step("syscall_drain2", 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 5'd6, 32'hCAFE_F0FF);
        idle();
        step("syscall_idle", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'd6, 32'hCAFE_F0FF);
        drive(1, ERTN, 14'h0, 0, 0, 0, 0, 0, 0);
        step("ertn_ret", 1, 0, 0, 1, 0, 0, 1, 1, 32'h1C00_0104, 0, 5'd6, 32'hCAFE_F0FF);
        idle();
        step("ertn_drain1", 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 5'd6, 32'hCAFE_F0FF);
        step("ertn_drain2", 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 5'd6, 32'hCAFE_F0FF);
        step("ertn_idle", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'd6, 32'hCAFE_F0FF);
        drive(1, WR, 14'h30, 32'h99, 0, 7, 1, 6'h08, 9'h001);
        step("exc_over_csrwr", 1, 0, 1, 0, 6'h08, 9'h001, 0, 0, 0, 0, 5'd6, 32'hCAFE_F0FF);
        idle();
        step("exc_redirect", 0, 0, 0, 0, 0, 0, 1, 1, 32'h1C00_8000, 0, 5'd6, 32'hCAFE_F0FF);
        reset = 1;
        step("reset_in_drain", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'd6, 32'hCAFE_F0FF);
        reset = 0;
        step("after_reset_idle", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'd0, 32'h0);
        drive(1, RD, 14'h30, 0, 0, 8, 0, 0, 0);
        step("csrrd_save0", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'd0, 32'h0);
        idle();
        step("save0_unchanged", 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5'd8, 32'h1234_5678);
`ifdef CSR_CTRL_INT_EN
        int_pending = 1;
        csr_crmd_ie = 1;
        drive(1, WR, 14'h30, 32'h77, 0, 9, 0, 0, 0);
        step("int_exc", 1, 0, 1, 0, 6'h00, 0, 0, 0, 0, 0, 5'd8, 32'h1234_5678);
        idle();
        step("int_redirect", 0, 0, 0, 0, 0, 0, 1, 1, 32'h1C00_8000, 0, 5'd8, 32'h1234_5678);
        step("int_drain1", 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 5'd8, 32'h1234_5678);
        step("int_drain2", 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 5'd8, 32'h1234_5678);
        csr_crmd_ie = 0;
        drive(1, WR, 14'h30, 32'h77, 0, 9, 0, 0, 0);
        step("int_masked_csrwr", 1, 2'b01, 0, 0, 0, 0, 0, 0, 0, 0, 5'd8, 32'h1234_5678);
        idle();
        int_pending = 0;
        step("int_masked_rf", 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5'd9, 32'h1234_5678);
`endif
        if (q.size() != 0) begin
            mismatched++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
